bin_seq_ctrl: RTL

Parametrised bin-sequencing controller: the next-generation control core of the bin manager. It walks the bins of a partitioned SAT instance and runs the same load, core-run, update and decide loop for each bin, driving the clause/var-state mover and one SAT engine core through explicit request/done handshakes. Compared with the previous generation it adds:
- non-chronological backtracking across bins;
- a configurable iteration limit with an abort result;
- saturating visit counting.

---
 rtl/bin_seq_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/bin_seq_ctrl.sv
// Bin-sequencing controller: walks the bins of a partitioned SAT instance, running
// load / core-run / update / decide for each bin with backtracking and an iteration limit.
module bin_seq_ctrl #(
  parameter int WIDTH_BIN_ID = 10,
  parameter int WIDTH_LVL    = 16,
  parameter int WIDTH_ITER   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [WIDTH_BIN_ID-1:0] nb_all_i,
  input  logic [WIDTH_ITER-1:0]   max_iter_i,
  output logic                    done_o,
  output logic                    global_sat_o,
  output logic                    global_unsat_o,
  output logic                    abort_o,
  output logic                    load_req_o,
  output logic [WIDTH_BIN_ID-1:0] load_bin_o,
  input  logic                    load_done_i,
  output logic                    start_core_o,
  input  logic                    done_core_i,
  input  logic                    local_sat_i,
  input  logic                    local_unsat_i,
  input  logic [WIDTH_LVL-1:0]    cur_lvl_from_core_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_from_core_i,
  input  logic [WIDTH_LVL-1:0]    bkt_lvl_from_core_i,
  output logic                    upd_req_o,
  output logic [WIDTH_BIN_ID-1:0] upd_bin_o,
  input  logic                    upd_done_i,
  output logic [WIDTH_BIN_ID-1:0] cur_bin_num_o,
  output logic [WIDTH_LVL-1:0]    cur_lvl_o,
  output logic [WIDTH_LVL-1:0]    base_lvl_o,
  output logic [WIDTH_ITER-1:0]   iter_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT,
    S_UPDATE,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [WIDTH_BIN_ID-1:0] r_nb;
  logic [WIDTH_ITER-1:0]   r_max_iter;
  logic [WIDTH_BIN_ID-1:0] r_cur_bin;
  logic [WIDTH_LVL-1:0]    r_cur_lvl;
  logic [WIDTH_LVL-1:0]    r_base_lvl;
  logic [WIDTH_ITER-1:0]   r_iter;
  logic                    r_unsat;
  logic [WIDTH_BIN_ID-1:0] r_bkt_bin;
  logic [WIDTH_LVL-1:0]    r_bkt_lvl;
  logic                    r_gsat;
  logic                    r_gunsat;
  logic                    r_abort;

  logic [WIDTH_ITER-1:0]   w_iter_inc;
  logic                    w_last_bin;
  logic                    w_limit;
  logic                    w_adv;
  logic                    w_bkt;
  logic                    w_fin_sat;
  logic                    w_fin_unsat;
  logic                    w_fin_abort;

  assign w_iter_inc = (r_iter == '1) ? r_iter : r_iter + WIDTH_ITER'(1);
  assign w_last_bin = (r_cur_bin == r_nb - WIDTH_BIN_ID'(1));
  assign w_limit    = (r_max_iter != '0) && (w_iter_inc == r_max_iter);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    load_req_o   = 1'b0;
    load_bin_o   = '0;
    start_core_o = 1'b0;
    upd_req_o    = 1'b0;
    upd_bin_o    = '0;
    done_o       = 1'b0;
    w_adv        = 1'b0;
    w_bkt        = 1'b0;
    w_fin_sat    = 1'b0;
    w_fin_unsat  = 1'b0;
    w_fin_abort  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) w_next_state = (nb_all_i == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        load_req_o = 1'b1;
        load_bin_o = r_cur_bin;
        if (load_done_i) w_next_state = S_RUN;
      end
      S_RUN: begin
        start_core_o = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (done_core_i) w_next_state = S_UPDATE;
      end
      S_UPDATE: begin
        upd_req_o = 1'b1;
        upd_bin_o = r_cur_bin;
        if (upd_done_i) w_next_state = S_DECIDE;
      end
      S_DECIDE: begin
        // Terminating results are checked before the limit, so they win over abort.
        w_next_state = S_DONE;
        if (!r_unsat) begin
          if (w_last_bin)   w_fin_sat = 1'b1;
          else if (w_limit) w_fin_abort = 1'b1;
          else begin
            w_adv        = 1'b1;
            w_next_state = S_LOAD;
          end
        end else begin
          if ((r_bkt_lvl == '0) || (r_bkt_bin >= r_nb)) w_fin_unsat = 1'b1;
          else if (w_limit)                             w_fin_abort = 1'b1;
          else begin
            w_bkt        = 1'b1;
            w_next_state = S_LOAD;
          end
        end
      end
      S_DONE: begin
        done_o       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nb       <= '0;
      r_max_iter <= '0;
      r_cur_bin  <= '0;
      r_cur_lvl  <= '0;
      r_base_lvl <= '0;
      r_iter     <= '0;
      r_unsat    <= 1'b0;
      r_bkt_bin  <= '0;
      r_bkt_lvl  <= '0;
      r_gsat     <= 1'b0;
      r_gunsat   <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_nb       <= nb_all_i;
            r_max_iter <= max_iter_i;
            r_cur_bin  <= '0;
            r_cur_lvl  <= '0;
            r_base_lvl <= '0;
            r_iter     <= '0;
            r_gsat     <= (nb_all_i == '0);
            r_gunsat   <= 1'b0;
            r_abort    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (load_done_i) r_base_lvl <= r_cur_lvl;
        end
        S_WAIT: begin
          if (done_core_i) begin
            // A visit reporting neither flag counts as sat; unsat wins when both are set.
            r_unsat   <= local_unsat_i;
            r_bkt_bin <= bkt_bin_from_core_i;
            r_bkt_lvl <= bkt_lvl_from_core_i;
            r_cur_lvl <= cur_lvl_from_core_i;
          end
        end
        S_DECIDE: begin
          r_iter <= w_iter_inc;
          if (w_adv) r_cur_bin <= r_cur_bin + WIDTH_BIN_ID'(1);
          if (w_bkt) begin
            r_cur_bin <= r_bkt_bin;
            r_cur_lvl <= r_bkt_lvl;
          end
          if (w_fin_sat)   r_gsat   <= 1'b1;
          if (w_fin_unsat) r_gunsat <= 1'b1;
          if (w_fin_abort) r_abort  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign global_sat_o   = r_gsat;
  assign global_unsat_o = r_gunsat;
  assign abort_o        = r_abort;
  assign cur_bin_num_o  = r_cur_bin;
  assign cur_lvl_o      = r_cur_lvl;
  assign base_lvl_o     = r_base_lvl;
  assign iter_cnt_o     = r_iter;

endmodule
